// File: rtl/led_sched_pkg.sv
// Shared types for the scheduled LED pattern engine: pattern modes and the
// packed configuration word held while a new setting waits for its apply point.
package led_sched_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_e;

    localparam mode_e DEFAULT_MODE_C = MODE_BLINK;

    // Divisor field width; the controller's CNT_W defaults to this value.
    localparam int CFG_DIV_W = 26;

    typedef struct packed {
        mode_e                mode;
        logic [CFG_DIV_W-1:0] div;
    } cfg_t;

endpackage

// File: rtl/tick_prescaler.sv
// Shared step prescaler: counts enabled cycles up to a stored terminal value
// and emits a registered one-cycle tick on each wrap.
module tick_prescaler #(
    parameter int          CNT_W       = 26,
    parameter int unsigned DEFAULT_DIV = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             load,
    input  logic [CNT_W-1:0] load_term,
    output logic             wrap,
    output logic             tick
);

    localparam logic [CNT_W-1:0] RESET_TERM = CNT_W'(DEFAULT_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] term_q, term_d;
    logic             tick_q, tick_d;

    always_comb begin
        wrap   = enable && (cnt_q == term_q);
        cnt_d  = cnt_q;
        term_d = term_q;
        tick_d = wrap;
        // A load restarts the step from zero so no partial step uses the old divisor.
        if (load) begin
            cnt_d  = '0;
            term_d = load_term;
        end else if (wrap) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            term_q <= RESET_TERM;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            term_q <= term_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/led_sched_ctrl.sv
// Scheduled multi-LED pattern engine: valid/ready config port, a single pending
// slot applied on a step boundary, and the OFF/BLINK/CHASE/BOUNCE pattern FSM.
module led_sched_ctrl
    import led_sched_pkg::*;
#(
    parameter int          NUM_LEDS     = 3,
    parameter int          CNT_W        = CFG_DIV_W,
    parameter int unsigned DEFAULT_DIV  = 50_000_000,
    parameter logic [1:0]  DEFAULT_MODE = 2'(DEFAULT_MODE_C)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                enable,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [1:0]          cfg_mode,
    input  logic [CNT_W-1:0]    cfg_div,
    output logic [NUM_LEDS-1:0] led,
    output logic                tick,
    output logic [1:0]          mode_o
);

    logic                pending_q, pending_d;
    cfg_t                pend_q, pend_d;
    mode_e               mode_q, mode_d;
    logic [NUM_LEDS-1:0] led_q, led_d;
    logic                dir_up_q, dir_up_d;
    logic                accept, apply, wrap;
    logic [CNT_W-1:0]    div_clamped;
    logic [CNT_W-1:0]    apply_term;

    function automatic logic [NUM_LEDS-1:0] init_led(input mode_e m);
        logic [NUM_LEDS-1:0] v;
        v = '0;
        if (m == MODE_CHASE || m == MODE_BOUNCE) v[0] = 1'b1;
        return v;
    endfunction

    tick_prescaler #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_prescaler (
        .clk       (CLK),
        .rst       (RST),
        .enable    (enable),
        .load      (apply),
        .load_term (apply_term),
        .wrap      (wrap),
        .tick      (tick)
    );

    always_comb begin
        accept      = cfg_valid && !pending_q;
        // With the prescaler frozen there is no wrap to wait for, so apply at once.
        apply       = pending_q && (wrap || !enable);
        div_clamped = (cfg_div == '0) ? CNT_W'(1) : cfg_div;
        apply_term  = CNT_W'(pend_q.div) - 1'b1;

        pending_d = pending_q;
        pend_d    = pend_q;
        mode_d    = mode_q;
        led_d     = led_q;
        dir_up_d  = dir_up_q;

        if (apply) begin
            pending_d = 1'b0;
        end else if (accept) begin
            pending_d   = 1'b1;
            pend_d.mode = mode_e'(cfg_mode);
            pend_d.div  = CFG_DIV_W'(div_clamped);
        end

        if (apply) begin
            mode_d   = pend_q.mode;
            led_d    = init_led(pend_q.mode);
            dir_up_d = 1'b1;
        end else if (wrap) begin
            case (mode_q)
                MODE_OFF:    led_d = '0;
                MODE_BLINK:  led_d = ~led_q;
                MODE_CHASE:  led_d = {led_q[NUM_LEDS-2:0], led_q[NUM_LEDS-1]};
                MODE_BOUNCE: begin
                    // Turn around as soon as an end LED is lit, so ends dwell one step.
                    if (dir_up_q) begin
                        if (led_q[NUM_LEDS-1]) begin
                            led_d    = led_q >> 1;
                            dir_up_d = 1'b0;
                        end else begin
                            led_d = led_q << 1;
                        end
                    end else begin
                        if (led_q[0]) begin
                            led_d    = led_q << 1;
                            dir_up_d = 1'b1;
                        end else begin
                            led_d = led_q >> 1;
                        end
                    end
                end
                default:     led_d = '0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pending_q <= 1'b0;
            pend_q    <= '0;
            mode_q    <= mode_e'(DEFAULT_MODE);
            led_q     <= '0;
            dir_up_q  <= 1'b1;
        end else begin
            pending_q <= pending_d;
            pend_q    <= pend_d;
            mode_q    <= mode_d;
            led_q     <= led_d;
            dir_up_q  <= dir_up_d;
        end
    end

    assign cfg_ready = !pending_q;
    assign led       = led_q;
    assign mode_o    = mode_q;

endmodule

// File: tb/tb_led_sched_ctrl.sv
// Directed bench for led_sched_ctrl with a short default divisor; each check
// compares the packed status {cfg_ready, tick, mode_o, led} against a traced value.
module tb_led_sched_ctrl;

    localparam int NUM_LEDS = 3;
    localparam int CNT_W    = 26;

    logic                CLK;
    logic                RST;
    logic                enable;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [1:0]          cfg_mode;
    logic [CNT_W-1:0]    cfg_div;
    logic [NUM_LEDS-1:0] led;
    logic                tick;
    logic [1:0]          mode_o;

    int                  n_cmp;
    int                  n_bad;
    logic [6:0]          st;
    logic [6:0]          ex;

    led_sched_ctrl #(
        .NUM_LEDS     (NUM_LEDS),
        .CNT_W        (CNT_W),
        .DEFAULT_DIV  (4),
        .DEFAULT_MODE (2'd1)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .enable    (enable),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_mode  (cfg_mode),
        .cfg_div   (cfg_div),
        .led       (led),
        .tick      (tick),
        .mode_o    (mode_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [6:0] mk(input logic r, input logic t,
                                      input logic [1:0] m, input logic [2:0] l);
        return {r, t, m, l};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; enable = 1'b1; cfg_valid = 1'b0; cfg_mode = 2'd0; cfg_div = '0;
        step();
        step();
        ex = mk(1'b1, 1'b0, 2'd1, 3'b000);
        st = {cfg_ready, tick, mode_o, led};
        n_cmp++;
        if (st !== ex) begin n_bad++; $display("FAIL reset: got %b required %b", st, ex); end
        RST = 1'b0;
    endtask

    task automatic test_blink_default();
        for (int k = 1; k <= 12; k++) begin
            step();
            ex = mk(1'b1, (k % 4) == 0, 2'd1, ((k / 4) % 2) != 0 ? 3'b111 : 3'b000);
            st = {cfg_ready, tick, mode_o, led};
            n_cmp++;
            if (st !== ex) begin n_bad++; $display("FAIL blink[%0d]: got %b required %b", k, st, ex); end
        end
    endtask

    task automatic test_chase_cfg();
        logic [6:0] pre [4];
        logic [2:0] seq [9];
        pre = '{mk(1, 0, 1, 3'b111), mk(0, 0, 1, 3'b111), mk(0, 0, 1, 3'b111), mk(1, 1, 2, 3'b001)};
        seq = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b010, 3'b100, 3'b100, 3'b100, 3'b001};
        for (int k = 0; k < 4; k++) begin
            step();
            if (k == 0) begin cfg_valid = 1'b1; cfg_mode = 2'd2; cfg_div = 26'd3; end
            if (k == 1) cfg_valid = 1'b0;
            st = {cfg_ready, tick, mode_o, led};
            n_cmp++;
            if (st !== pre[k]) begin n_bad++; $display("FAIL chase_apply[%0d]: got %b required %b", k, st, pre[k]); end
        end
        for (int k = 1; k <= 9; k++) begin
            step();
            ex = mk(1'b1, (k % 3) == 0, 2'd2, seq[k-1]);
            st = {cfg_ready, tick, mode_o, led};
            n_cmp++;
            if (st !== ex) begin n_bad++; $display("FAIL chase_seq[%0d]: got %b required %b", k, st, ex); end
        end
    endtask

    task automatic test_bounce_div1();
        logic [6:0] pre [3];
        logic [2:0] seq [5];
        pre = '{mk(0, 0, 2, 3'b001), mk(0, 0, 2, 3'b001), mk(1, 1, 3, 3'b001)};
        seq = '{3'b010, 3'b100, 3'b010, 3'b001, 3'b010};
        cfg_valid = 1'b1; cfg_mode = 2'd3; cfg_div = 26'd1;
        for (int k = 0; k < 3; k++) begin
            step();
            cfg_valid = 1'b0;
            st = {cfg_ready, tick, mode_o, led};
            n_cmp++;
            if (st !== pre[k]) begin n_bad++; $display("FAIL bounce_apply[%0d]: got %b required %b", k, st, pre[k]); end
        end
        for (int k = 0; k < 5; k++) begin
            step();
            ex = mk(1'b1, 1'b1, 2'd3, seq[k]);
            st = {cfg_ready, tick, mode_o, led};
            n_cmp++;
            if (st !== ex) begin n_bad++; $display("FAIL bounce_seq[%0d]: got %b required %b", k, st, ex); end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] pre [2];
        pre = '{mk(0, 1, 3, 3'b100), mk(1, 1, 1, 3'b000)};
        cfg_valid = 1'b1; cfg_mode = 2'd1; cfg_div = 26'd5;
        for (int k = 0; k < 2; k++) begin
            step();
            cfg_valid = 1'b0;
            st = {cfg_ready, tick, mode_o, led};
            n_cmp++;
            if (st !== pre[k]) begin n_bad++; $display("FAIL capture_on_wrap[%0d]: got %b required %b", k, st, pre[k]); end
        end
    endtask

    task automatic test_enable_freeze();
        for (int k = 1; k <= 7; k++) begin
            step();
            ex = mk(1'b1, k == 5, 2'd1, k >= 5 ? 3'b111 : 3'b000);
            st = {cfg_ready, tick, mode_o, led};
            n_cmp++;
            if (st !== ex) begin n_bad++; $display("FAIL pre_freeze[%0d]: got %b required %b", k, st, ex); end
        end
        enable = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            ex = mk(1'b1, 1'b0, 2'd1, 3'b111);
            st = {cfg_ready, tick, mode_o, led};
            n_cmp++;
            if (st !== ex) begin n_bad++; $display("FAIL frozen[%0d]: got %b required %b", k, st, ex); end
        end
        enable = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            ex = mk(1'b1, k == 3, 2'd1, k == 3 ? 3'b000 : 3'b111);
            st = {cfg_ready, tick, mode_o, led};
            n_cmp++;
            if (st !== ex) begin n_bad++; $display("FAIL resume[%0d]: got %b required %b", k, st, ex); end
        end
        enable = 1'b0; cfg_valid = 1'b1; cfg_mode = 2'd2; cfg_div = 26'd7;
        step();
        cfg_valid = 1'b0;
        ex = mk(1'b0, 1'b0, 2'd1, 3'b000);
        st = {cfg_ready, tick, mode_o, led};
        n_cmp++;
        if (st !== ex) begin n_bad++; $display("FAIL disabled_capture: got %b required %b", st, ex); end
        step();
        ex = mk(1'b1, 1'b0, 2'd2, 3'b001);
        st = {cfg_ready, tick, mode_o, led};
        n_cmp++;
        if (st !== ex) begin n_bad++; $display("FAIL disabled_apply: got %b required %b", st, ex); end
    endtask

    task automatic test_div0_holdoff();
        enable = 1'b1; cfg_valid = 1'b1; cfg_mode = 2'd1; cfg_div = '0;
        step();
        ex = mk(1'b0, 1'b0, 2'd2, 3'b001);
        st = {cfg_ready, tick, mode_o, led};
        n_cmp++;
        if (st !== ex) begin n_bad++; $display("FAIL div0_capture: got %b required %b", st, ex); end
        cfg_mode = 2'd3; cfg_div = 26'd2;
        for (int k = 1; k <= 5; k++) begin
            step();
            ex = mk(1'b0, 1'b0, 2'd2, 3'b001);
            st = {cfg_ready, tick, mode_o, led};
            n_cmp++;
            if (st !== ex) begin n_bad++; $display("FAIL holdoff[%0d]: got %b required %b", k, st, ex); end
        end
        step();
        ex = mk(1'b1, 1'b1, 2'd1, 3'b000);
        st = {cfg_ready, tick, mode_o, led};
        n_cmp++;
        if (st !== ex) begin n_bad++; $display("FAIL div0_apply: got %b required %b", st, ex); end
        step();
        cfg_valid = 1'b0;
        ex = mk(1'b0, 1'b1, 2'd1, 3'b111);
        st = {cfg_ready, tick, mode_o, led};
        n_cmp++;
        if (st !== ex) begin n_bad++; $display("FAIL div0_as_div1: got %b required %b", st, ex); end
        step();
        ex = mk(1'b1, 1'b1, 2'd3, 3'b001);
        st = {cfg_ready, tick, mode_o, led};
        n_cmp++;
        if (st !== ex) begin n_bad++; $display("FAIL second_cfg_apply: got %b required %b", st, ex); end
    endtask

    task automatic test_reset_pending();
        logic [6:0] seq [4];
        seq = '{mk(1, 0, 3, 3'b001), mk(1, 1, 3, 3'b010), mk(1, 0, 3, 3'b010), mk(0, 1, 3, 3'b100)};
        for (int k = 0; k < 4; k++) begin
            step();
            if (k == 2) begin cfg_valid = 1'b1; cfg_mode = 2'd2; cfg_div = 26'd9; end
            if (k == 3) cfg_valid = 1'b0;
            st = {cfg_ready, tick, mode_o, led};
            n_cmp++;
            if (st !== seq[k]) begin n_bad++; $display("FAIL bounce_div2[%0d]: got %b required %b", k, st, seq[k]); end
        end
        RST = 1'b1;
        step();
        RST = 1'b0;
        ex = mk(1'b1, 1'b0, 2'd1, 3'b000);
        st = {cfg_ready, tick, mode_o, led};
        n_cmp++;
        if (st !== ex) begin n_bad++; $display("FAIL reset_pending: got %b required %b", st, ex); end
        for (int k = 1; k <= 4; k++) begin
            step();
            ex = mk(1'b1, k == 4, 2'd1, k == 4 ? 3'b111 : 3'b000);
            st = {cfg_ready, tick, mode_o, led};
            n_cmp++;
            if (st !== ex) begin n_bad++; $display("FAIL post_reset[%0d]: got %b required %b", k, st, ex); end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_blink_default();
        test_chase_cfg();
        test_bounce_div1();
        test_back_to_back();
        test_enable_freeze();
        test_div0_holdoff();
        test_reset_pending();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
